btn_debounce_scan: RTL and testbench

- Parametrised N-channel button front end for board-level push-buttons and switches.
- Synchronises raw pad inputs and samples them on a slow scan tick. Each channel is debounced with a consecutive-sample filter.
- Emits, per channel: a debounced level, single-cycle press/release pulses, and optional auto-repeat pulses while held.
- Sits between top-level pad inputs and control/UI logic; produces the debounced button vector consumed downstream.

---
 rtl/btn_debounce_scan.sv | 166 ++++++++++++++++
 tb/tb_btn_debounce_scan.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_scan.sv
// N-channel push-button front end: two-flop synchroniser, scan-tick sampling,
// consecutive-sample debounce, press/release pulses and optional auto-repeat.
module btn_debounce_scan #(
  parameter int CLK_FREQ       = 100,
  parameter int SCAN_US        = 10000,
  parameter int NUM_BTN        = 2,
  parameter int ACTIVE_LOW     = 0,
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_TICKS     = 50,
  parameter int REPEAT_TICKS   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_btn_in,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [NUM_BTN-1:0] o_repeat,
  output logic               o_any_press,
  output logic               o_tick
);

  function automatic int GET_WIDTH(input int value);
    int w;
    w = 1;
    for (int b = 1; b < 31; b++) begin
      if ((value >> b) != 0) begin
        w = b + 1;
      end
    end
    return w;
  endfunction

  localparam int TICK_CYCLES = CLK_FREQ * SCAN_US;
  localparam int DIV_W       = GET_WIDTH(TICK_CYCLES - 1);
  localparam int STAB_W      = GET_WIDTH(STABLE_SAMPLES);
  localparam int HOLD_W      = GET_WIDTH((HOLD_TICKS > 0) ? HOLD_TICKS : 1);
  localparam bit REPEAT_EN   = (HOLD_TICKS > 0);

  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(TICK_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_TARGET = STAB_W'(STABLE_SAMPLES);
  localparam logic [HOLD_W-1:0]  HOLD_TARGET = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD =
    HOLD_W'((HOLD_TICKS > 0) ? (HOLD_TICKS - REPEAT_TICKS) : 0);
  localparam logic [NUM_BTN-1:0] INACTIVE =
    (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [DIV_W-1:0]   r_div;
  logic [STAB_W-1:0]  r_stab [NUM_BTN];
  logic [HOLD_W-1:0]  r_hold [NUM_BTN];
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;
  logic [NUM_BTN-1:0] r_repeat;
  logic               r_any;

  logic [NUM_BTN-1:0] w_s;
  logic               w_tick;
  logic [NUM_BTN-1:0] w_flip;
  logic [STAB_W-1:0]  w_stab_nxt [NUM_BTN];
  logic [HOLD_W-1:0]  w_hold_nxt [NUM_BTN];
  logic [NUM_BTN-1:0] w_level_nxt;
  logic [NUM_BTN-1:0] w_press_nxt;
  logic [NUM_BTN-1:0] w_release_nxt;
  logic [NUM_BTN-1:0] w_repeat_nxt;

  assign w_s    = r_sync2 ^ INACTIVE;
  assign w_tick = (r_div == DIV_LAST);

  // Synchroniser flops and scan-tick divider
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= INACTIVE;
      r_sync2 <= INACTIVE;
      r_div   <= {DIV_W{1'b0}};
    end else begin
      r_sync1 <= i_btn_in;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_div <= {DIV_W{1'b0}};
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  // A channel flips on the tick that completes its run of differing samples
  always_comb begin
    w_flip = {NUM_BTN{1'b0}};
    for (int i = 0; i < NUM_BTN; i++) begin
      w_flip[i] = w_tick && (w_s[i] != r_level[i]) &&
                  ((r_stab[i] + STAB_W'(1)) == STAB_TARGET);
    end
  end

  // Per-channel debounce and hold/repeat next state
  always_comb begin
    w_level_nxt   = r_level;
    w_press_nxt   = {NUM_BTN{1'b0}};
    w_release_nxt = {NUM_BTN{1'b0}};
    w_repeat_nxt  = {NUM_BTN{1'b0}};
    for (int i = 0; i < NUM_BTN; i++) begin
      w_stab_nxt[i] = r_stab[i];
      w_hold_nxt[i] = r_hold[i];
      if (w_tick) begin
        if (w_s[i] == r_level[i]) begin
          w_stab_nxt[i] = {STAB_W{1'b0}};
        end else if (w_flip[i]) begin
          w_stab_nxt[i]    = {STAB_W{1'b0}};
          w_level_nxt[i]   = w_s[i];
          w_press_nxt[i]   = w_s[i];
          w_release_nxt[i] = ~w_s[i];
        end else begin
          w_stab_nxt[i] = r_stab[i] + STAB_W'(1);
        end
        // A qualifying release pre-empts any repeat due on the same tick
        if (!REPEAT_EN || !r_level[i] || w_flip[i]) begin
          w_hold_nxt[i] = {HOLD_W{1'b0}};
        end else if ((r_hold[i] + HOLD_W'(1)) == HOLD_TARGET) begin
          w_repeat_nxt[i] = 1'b1;
          w_hold_nxt[i]   = HOLD_RELOAD;
        end else begin
          w_hold_nxt[i] = r_hold[i] + HOLD_W'(1);
        end
      end else begin
        w_stab_nxt[i] = r_stab[i];
        w_hold_nxt[i] = r_hold[i];
      end
    end
  end

  // Registered channel state and one-cycle pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level   <= {NUM_BTN{1'b0}};
      r_press   <= {NUM_BTN{1'b0}};
      r_release <= {NUM_BTN{1'b0}};
      r_repeat  <= {NUM_BTN{1'b0}};
      r_any     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_stab[i] <= {STAB_W{1'b0}};
        r_hold[i] <= {HOLD_W{1'b0}};
      end
    end else begin
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_repeat  <= w_repeat_nxt;
      r_any     <= |w_press_nxt;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_stab[i] <= w_stab_nxt[i];
        r_hold[i] <= w_hold_nxt[i];
      end
    end
  end

  assign o_level     = r_level;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_repeat    = r_repeat;
  assign o_any_press = r_any;
  assign o_tick      = w_tick;

endmodule

// File: tb/tb_btn_debounce_scan.sv
// Scoreboard bench: a tick-level reference model predicts every cycle's outputs
// for an active-high and an active-low instance driven with the same buttons.
module tb_btn_debounce_scan;

  localparam int NB     = 4;
  localparam int TICK   = 4;
  localparam int STABLE = 3;
  localparam int HOLD   = 5;
  localparam int REP    = 2;

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] rep;
    logic          any;
    logic          tick;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_drv;
  logic [NB-1:0] btn_drv;
  logic [NB-1:0] btn_lo;

  logic [NB-1:0] hi_level, hi_press, hi_rel, hi_rep;
  logic          hi_any, hi_tick;
  logic [NB-1:0] lo_level, lo_press, lo_rel, lo_rep;
  logic          lo_any, lo_tick;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  int            m_cnt;
  int            m_tk;
  logic [NB-1:0] m_p1, m_p2, m_lvl;
  int            m_hist [NB];
  int            m_pt   [NB];

  always #5 clk = ~clk;
  assign btn_lo = ~btn_drv;

  btn_debounce_scan #(
    .CLK_FREQ(1), .SCAN_US(4), .NUM_BTN(NB), .ACTIVE_LOW(0),
    .STABLE_SAMPLES(STABLE), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
  ) u_dut_hi (
    .clk(clk), .rst(rst_drv), .i_btn_in(btn_drv),
    .o_level(hi_level), .o_press(hi_press), .o_release(hi_rel),
    .o_repeat(hi_rep), .o_any_press(hi_any), .o_tick(hi_tick)
  );

  btn_debounce_scan #(
    .CLK_FREQ(1), .SCAN_US(4), .NUM_BTN(NB), .ACTIVE_LOW(1),
    .STABLE_SAMPLES(STABLE), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
  ) u_dut_lo (
    .clk(clk), .rst(rst_drv), .i_btn_in(btn_lo),
    .o_level(lo_level), .o_press(lo_press), .o_release(lo_rel),
    .o_repeat(lo_rep), .o_any_press(lo_any), .o_tick(lo_tick)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: a level flips once its last STABLE tick samples all disagree with it;
  // repeats fall HOLD ticks after the press and every REP ticks thereafter.
  task automatic model_edge();
    exp_t          r;
    logic [NB-1:0] s;
    int            d;
    int            mask;
    mask = (1 << STABLE) - 1;
    r = '0;
    if (rst_drv) begin
      m_p1 = '0; m_p2 = '0; m_lvl = '0;
      m_cnt = 0; m_tk = 0;
      for (int c = 0; c < NB; c++) begin
        m_hist[c] = 0;
        m_pt[c]   = 0;
      end
    end else begin
      s    = m_p2;
      m_p2 = m_p1;
      m_p1 = btn_drv;
      m_cnt++;
      if ((m_cnt % TICK) == 0) begin
        m_tk++;
        for (int c = 0; c < NB; c++) begin
          m_hist[c] = ((m_hist[c] << 1) | int'(s[c])) & mask;
          if (m_hist[c] == (m_lvl[c] ? 0 : mask)) begin
            if (m_lvl[c]) begin
              r.rel[c] = 1'b1;
            end else begin
              r.press[c] = 1'b1;
              m_pt[c]    = m_tk;
            end
            m_lvl[c] = ~m_lvl[c];
          end else if (m_lvl[c]) begin
            d = m_tk - m_pt[c];
            if (d >= HOLD && ((d - HOLD) % REP) == 0) r.rep[c] = 1'b1;
          end
        end
      end
      r.level = m_lvl;
      r.any   = |r.press;
      r.tick  = ((m_cnt % TICK) == TICK - 1);
    end
    exp_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n * TICK) step();
  endtask

  // Monitor: compare both instances against the predicted record for this cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("hi.level",   32'(hi_level), 32'(mon_e.level));
        chk("hi.press",   32'(hi_press), 32'(mon_e.press));
        chk("hi.release", 32'(hi_rel),   32'(mon_e.rel));
        chk("hi.repeat",  32'(hi_rep),   32'(mon_e.rep));
        chk("hi.any",     32'(hi_any),   32'(mon_e.any));
        chk("hi.tick",    32'(hi_tick),  32'(mon_e.tick));
        chk("lo.level",   32'(lo_level), 32'(mon_e.level));
        chk("lo.press",   32'(lo_press), 32'(mon_e.press));
        chk("lo.release", 32'(lo_rel),   32'(mon_e.rel));
        chk("lo.repeat",  32'(lo_rep),   32'(mon_e.rep));
        chk("lo.any",     32'(lo_any),   32'(mon_e.any));
        chk("lo.tick",    32'(lo_tick),  32'(mon_e.tick));
      end
    end
  end

  initial begin
    rst_drv = 1'b1;
    btn_drv = '0;
    repeat (3) step();
    rst_drv = 1'b0;
    ticks(4);
    btn_drv[0] = 1'b1; ticks(6);
    btn_drv[1] = 1'b1; ticks(2);
    btn_drv[1] = 1'b0; ticks(4);
    btn_drv[2] = 1'b1; ticks(16);
    btn_drv[2] = 1'b0; ticks(6);
    // Release of channel 3 lands on its second repeat tick
    btn_drv[3] = 1'b1; ticks(7);
    btn_drv[3] = 1'b0; ticks(6);
    rst_drv = 1'b1; repeat (2) step();
    rst_drv = 1'b0; btn_drv = '0; ticks(6);
    for (int k = 0; k < 2400; k++) begin
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 47) == 0) btn_drv[c] = ~btn_drv[c];
      end
      rst_drv = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_drv = 1'b0;
    btn_drv = '0;
    ticks(6);
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
